// File: rtl/soc_system_fifo_wr_arbiter.sv
// Round-robin write arbiter that shares one FIFO write port between two streaming requesters.
// Bursts are bounded, writes are throttled by the FIFO full flag, and a small CSR slave exposes the counters.
module soc_system_fifo_wr_arbiter #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              fifo_wrfull,
  output logic              fifo_wrreq,
  output logic [DATA_W-1:0] fifo_data,
  input  logic [1:0]        address,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata
);

  localparam int unsigned CNT_W   = 32;
  localparam int unsigned BURST_W = 8;
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t             state;
  logic               last_served;
  logic [BURST_W-1:0] burst_cnt;
  logic [CNT_W-1:0]   cnt0;
  logic [CNT_W-1:0]   cnt1;
  logic [CNT_W-1:0]   stall_cnt;

  logic granted;
  logic gnt_valid;
  logic oth_valid;
  logic gnt_is1;
  logic accept;
  logic stall;
  logic burst_done;
  logic release_now;
  logic csr_clear;
  logic unused_wdata;

  assign unused_wdata = ^writedata[31:1];

  // Datapath is a combinational pass-through so a full FIFO stops the word in the same cycle.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    fifo_wrreq = 1'b0;
    fifo_data  = '0;
    case (state)
      GRANT0: begin
        req0_ready = !fifo_wrfull;
        fifo_wrreq = req0_valid && !fifo_wrfull;
        fifo_data  = req0_data;
      end
      GRANT1: begin
        req1_ready = !fifo_wrfull;
        fifo_wrreq = req1_valid && !fifo_wrfull;
        fifo_data  = req1_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    granted   = (state == GRANT0) || (state == GRANT1);
    gnt_is1   = (state == GRANT1);
    gnt_valid = 1'b0;
    oth_valid = 1'b0;
    if (state == GRANT0) begin
      gnt_valid = req0_valid;
      oth_valid = req1_valid;
    end else if (state == GRANT1) begin
      gnt_valid = req1_valid;
      oth_valid = req0_valid;
    end
    accept      = fifo_wrreq;
    stall       = granted && gnt_valid && fifo_wrfull;
    burst_done  = accept && ((burst_cnt + BURST_W'(1)) == BURST_LAST);
    release_now = granted && (!gnt_valid || burst_done);
    csr_clear   = write && (address == 2'd0) && writedata[0];
  end

  // Arbitration state, burst length and release bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_served <= 1'b1;
      burst_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          burst_cnt <= '0;
          if (req0_valid && req1_valid) begin
            state <= last_served ? GRANT0 : GRANT1;
          end else if (req0_valid) begin
            state <= GRANT0;
          end else if (req1_valid) begin
            state <= GRANT1;
          end
        end
        GRANT0, GRANT1: begin
          if (release_now) begin
            last_served <= gnt_is1;
            burst_cnt   <= '0;
            if (oth_valid) begin
              state <= gnt_is1 ? GRANT0 : GRANT1;
            end else if (!gnt_valid) begin
              state <= IDLE;
            end
          end else if (accept) begin
            burst_cnt <= burst_cnt + BURST_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          burst_cnt <= '0;
        end
      endcase
    end
  end

  // Software-visible counters; a clear request overrides any increment in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0      <= '0;
      cnt1      <= '0;
      stall_cnt <= '0;
    end else if (csr_clear) begin
      cnt0      <= '0;
      cnt1      <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept && !gnt_is1) cnt0 <= cnt0 + CNT_W'(1);
      if (accept && gnt_is1)  cnt1 <= cnt1 + CNT_W'(1);
      if (stall)              stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      case (address)
        2'd0:    readdata <= {29'd0, last_served, state};
        2'd1:    readdata <= cnt0;
        2'd2:    readdata <= cnt1;
        default: readdata <= stall_cnt;
      endcase
    end
  end

endmodule
